decode_regfile_stage: RTL
=========================

Name: decode_regfile_stage

Overview:
- Decode-side consumer of the write-back interface.
- Holds the 8 x 16-bit architectural register file.
- Accepts the WB write triple (loadData, loadAddr, regWriteOut) on its write port.
- Reads two source operands per instruction and registers them, with decoded fields, into the ID/EX pipeline register.
- Supports stall (hold) and flush (bubble) from hazard control.

Parameters:
- DATA_W, 16, register/data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, register count (2**ADDR_W)
- CTRL_W, 8, width of opaque control bundle passed to EX

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold ID/EX register contents
- flush  in  1  insert bubble into ID/EX
- validIn  in  1  decode slot holds a real instruction
- rs1Addr  in  ADDR_W  source 1 register index
- rs2Addr  in  ADDR_W  source 2 register index
- rdIn  in  ADDR_W  destination register index
- immIn  in  DATA_W  sign-extended immediate
- pcIn  in  DATA_W  PC of decoded instruction
- ctrlIn  in  CTRL_W  control bundle
- regWriteOut  in  1  WB write enable
- loadAddr  in  ADDR_W  WB destination index
- loadData  in  DATA_W  WB write data
- rs1Data  out  DATA_W  operand 1 to EX
- rs2Data  out  DATA_W  operand 2 to EX
- rs1EX  out  ADDR_W  registered rs1 index (for forwarding)
- rs2EX  out  ADDR_W  registered rs2 index
- rdEX  out  ADDR_W  registered destination
- immEX  out  DATA_W  registered immediate
- pcEX  out  DATA_W  registered PC
- ctrlEX  out  CTRL_W  registered control
- validEX  out  1  registered valid

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset:
  - All NUM_REGS registers clear to 0.
  - Every output clears to 0; validEX=0.
  - Reset overrides write, stall and flush.
- Register 0:
  - Hardwired zero; writes with loadAddr=0 are discarded.
  - Reads of index 0 return 0, including when bypass would otherwise apply.
- Write port:
  - At a rising edge, if regWriteOut && loadAddr!=0, reg[loadAddr]<=loadData.
  - Writes are independent of stall/flush/validIn.
- Read with bypass (combinational, same cycle):
  - opX = (rsX==0) ? 0 : (regWriteOut && loadAddr==rsX) ? loadData : reg[rsX].
  - WB data written in cycle N is therefore visible to the instruction decoded in cycle N.
- ID/EX register update priority (highest first): reset, flush, stall, normal.
  - Flush: validEX=0, ctrlEX=0, all other outputs 0. Flush wins over simultaneous stall.
  - Stall: all outputs hold.
    - Refresh rule: if regWriteOut && loadAddr!=0 && loadAddr==rs1EX, rs1Data<=loadData (same for rs2EX/rs2Data), so held operands never go stale.
    - Both refreshes may occur in one cycle when rs1EX==rs2EX.
  - Normal: rs1Data<=op1, rs2Data<=op2, rs1EX<=rs1Addr, rs2EX<=rs2Addr, rdEX<=rdIn, immEX<=immIn, pcEX<=pcIn, ctrlEX<=ctrlIn, validEX<=validIn.
    - validIn=0 still captures fields; downstream gates on validEX.
- Latency: one cycle from decode inputs to EX outputs.
- Reset mid-operation: pending stall or held state is discarded; the first post-reset edge behaves as normal.

Optional Feature:
- Macro REGFILE_DEBUG_PORT_EN.
- Defined:
  - Adds input dbgAddr [ADDR_W] and output dbgData [DATA_W].
  - dbgData is a combinational raw read of reg[dbgAddr], with no bypass; index 0 returns 0.
- Undefined: ports absent; no logic generated.

Decomposition:
- Shared package holds:
  - DATA_W, ADDR_W, NUM_REGS, CTRL_W
  - REG_ZERO index constant
  - ID/EX bundle typedef (rs1/rs2 data and indices, rd, imm, pc, ctrl, valid)
- Natural sub-module: regfile_2r1w, containing the storage array, register-0 handling, write port and bypass muxes.
- The stage wrapper holds the ID/EX register and the stall/flush/refresh logic.

Test Plan:
- Reset: hold reset=1 for 1 cycle with regWriteOut=1, loadAddr=5, loadData=AAAA -> all outputs 0; then reset=0, rs1Addr=5 -> rs1Data=0 at next edge (write during reset discarded).
- Write then read: WB writes r3=BBBB; next cycle rs1Addr=3, rs2Addr=3 -> rs1Data=rs2Data=BBBB, rs1EX=3 after one edge.
- Same-cycle bypass and zero register:
  - WB writes r6=CCCC while rs2Addr=6 -> rs2Data=CCCC at the same edge.
  - WB writes r0=1234, rs1Addr=0 -> rs1Data=0.
- Stall refresh: capture rs1Addr=2 (r2=0011); stall=1 and WB writes r2=9999 -> rs1Data becomes 9999, while rdEX/pcEX/immEX hold.
- Flush over stall: stall=1, flush=1, validIn=1, ctrlIn=FF -> validEX=0, ctrlEX=0; next cycle both low, pcIn=0042 -> pcEX=0042, validEX=validIn.
- Debug port (with REGFILE_DEBUG_PORT_EN): write r7=7777, dbgAddr=7 -> dbgData=7777 after the edge, not during the write cycle.

Source files
------------

// File: rtl/decode_regfile_stage_pkg.sv
// Shared types and sizes for the decode/register-file stage.
// Optional raw debug read port: REGFILE_DEBUG_PORT_EN.
package decode_regfile_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CTRL_W   = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } id_ex_t;

endpackage

// File: rtl/decode_regfile_stage_if.sv
// Decode, write-back and ID/EX signal bundle.
// REGFILE_DEBUG_PORT_EN adds dbgAddr/dbgData.
interface decode_regfile_stage_if;
  import decode_regfile_stage_pkg::*;

  logic              stall;
  logic              flush;
  logic              validIn;
  logic [ADDR_W-1:0] rs1Addr;
  logic [ADDR_W-1:0] rs2Addr;
  logic [ADDR_W-1:0] rdIn;
  logic [DATA_W-1:0] immIn;
  logic [DATA_W-1:0] pcIn;
  logic [CTRL_W-1:0] ctrlIn;
  logic              regWriteOut;
  logic [ADDR_W-1:0] loadAddr;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] rs1Data;
  logic [DATA_W-1:0] rs2Data;
  logic [ADDR_W-1:0] rs1EX;
  logic [ADDR_W-1:0] rs2EX;
  logic [ADDR_W-1:0] rdEX;
  logic [DATA_W-1:0] immEX;
  logic [DATA_W-1:0] pcEX;
  logic [CTRL_W-1:0] ctrlEX;
  logic              validEX;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [ADDR_W-1:0] dbgAddr;
  logic [DATA_W-1:0] dbgData;
`endif

  modport master (
    output stall, flush, validIn,
    output rs1Addr, rs2Addr, rdIn,
    output immIn, pcIn, ctrlIn,
    output regWriteOut, loadAddr, loadData,
`ifdef REGFILE_DEBUG_PORT_EN
    output dbgAddr,
    input  dbgData,
`endif
    input  rs1Data, rs2Data,
    input  rs1EX, rs2EX, rdEX,
    input  immEX, pcEX, ctrlEX, validEX
  );

  modport slave (
    input  stall, flush, validIn,
    input  rs1Addr, rs2Addr, rdIn,
    input  immIn, pcIn, ctrlIn,
    input  regWriteOut, loadAddr, loadData,
`ifdef REGFILE_DEBUG_PORT_EN
    input  dbgAddr,
    output dbgData,
`endif
    output rs1Data, rs2Data,
    output rs1EX, rs2EX, rdEX,
    output immEX, pcEX, ctrlEX, validEX
  );

endinterface

// File: rtl/decode_regfile_stage_regfile_2r1w.sv
// 2-read 1-write register file, r0 hardwired to zero, WB bypass.
// REGFILE_DEBUG_PORT_EN adds an unbypassed debug read.
module regfile_2r1w
  import decode_regfile_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
`endif
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  assign wr_en = we_i && (waddr_i != REG_ZERO);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  function automatic logic [DATA_W-1:0] rd_byp(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] r;
    r = regs_q[a];
    if (a == REG_ZERO) r = '0;
    else if (we_i && waddr_i == a) r = wdata_i;
    return r;
  endfunction

  assign rdata1_o = rd_byp(raddr1_i);
  assign rdata2_o = rd_byp(raddr2_i);

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data_o = (dbg_addr_i == REG_ZERO) ? '0
                    : regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/decode_regfile_stage.sv
// Decode stage: register file read plus ID/EX pipeline register.
// REGFILE_DEBUG_PORT_EN exposes a raw register-file read.
module decode_regfile_stage
  import decode_regfile_stage_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  decode_regfile_stage_if.slave bus
);

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              wb_hit;
  id_ex_t            ex_q;
  id_ex_t            ex_d;

  regfile_2r1w u_rf (
    .clk_i      (clk),
    .rst_i      (reset),
    .we_i       (bus.regWriteOut),
    .waddr_i    (bus.loadAddr),
    .wdata_i    (bus.loadData),
    .raddr1_i   (bus.rs1Addr),
    .raddr2_i   (bus.rs2Addr),
    .rdata1_o   (op1),
    .rdata2_o   (op2)
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    .dbg_addr_i (bus.dbgAddr),
    .dbg_data_o (bus.dbgData)
`endif
  );

  assign wb_hit = bus.regWriteOut
               && (bus.loadAddr != REG_ZERO);

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.stall) begin
      // keep held operands coherent with WB
      if (wb_hit && bus.loadAddr == ex_q.rs1)
        ex_d.rs1_data = bus.loadData;
      if (wb_hit && bus.loadAddr == ex_q.rs2)
        ex_d.rs2_data = bus.loadData;
    end else begin
      ex_d.rs1_data = op1;
      ex_d.rs2_data = op2;
      ex_d.rs1      = bus.rs1Addr;
      ex_d.rs2      = bus.rs2Addr;
      ex_d.rd       = bus.rdIn;
      ex_d.imm      = bus.immIn;
      ex_d.pc       = bus.pcIn;
      ex_d.ctrl     = bus.ctrlIn;
      ex_d.valid    = bus.validIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.rs1Data = ex_q.rs1_data;
  assign bus.rs2Data = ex_q.rs2_data;
  assign bus.rs1EX   = ex_q.rs1;
  assign bus.rs2EX   = ex_q.rs2;
  assign bus.rdEX    = ex_q.rd;
  assign bus.immEX   = ex_q.imm;
  assign bus.pcEX    = ex_q.pc;
  assign bus.ctrlEX  = ex_q.ctrl;
  assign bus.validEX = ex_q.valid;

endmodule
